// File: rtl/accumulate_stage.sv
// accumulate_stage: sums N unsigned WIDTH-bit operands into one ACC_WIDTH-bit
// result through a ripple-carry adder fed back from the accumulator register.
// A sticky flag records any carry-out seen while building the current result.
//
// State table
//   state | meaning
//   ACCUM | accepting operands, in_ready high, cnt counts accepts
//   DONE  | result presented on out_sum/out_ovf, waiting for out_ready
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand on in_data is valid
//   in_ready   stage accepts an operand this cycle (combinational)
//   in_data    WIDTH-bit unsigned operand
//   out_valid  a completed result is presented (combinational)
//   out_ready  consumer takes the result this cycle
//   out_sum    accumulated sum modulo 2^ACC_WIDTH
//   out_ovf    set if any addition of this result carried out

module adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             co
);
    logic carry;

    always_comb begin
        carry = cin;
        out   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out[i] = in1[i] ^ in2[i] ^ carry;
            carry  = (in1[i] & in2[i]) | (carry & (in1[i] ^ in2[i]));
        end
        co = carry;
    end
endmodule

module accumulate_stage #(
    parameter int WIDTH     = 16,
    parameter int N         = 4,
    parameter int ACC_WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] opnd;
    logic [ACC_WIDTH-1:0] add_out;
    logic                 add_co;
    logic                 accept;

    // Zero-extend the operand; written this way so ACC_WIDTH == WIDTH is legal.
    always_comb begin
        opnd            = '0;
        opnd[WIDTH-1:0] = in_data;
    end

    adder #(.WIDTH(ACC_WIDTH)) u_adder (
        .in1 (acc_q),
        .in2 (opnd),
        .cin (1'b0),
        .out (add_out),
        .co  (add_co)
    );

    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = (state_q == DONE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

    // The adder output only reaches acc on an accept, so in_data outside an
    // accept (including X) never disturbs the accumulator.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = add_out;
                    ovf_d = ovf_q | add_co;
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
